// File: rtl/sipo_collector_pkg.sv
// rtl/sipo_collector_pkg.sv - shared constants for the sipo/piso serial stages
package sipo_collector_pkg;

  // Default serial word width shared with the upstream piso stage
  localparam int SIPO_WIDTH = 4;

  // Collector state encoding, kept numerically stable for the piso stage
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  function automatic logic state_busy(input logic [1:0] state);
    return state != ST_IDLE;
  endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// rtl/sipo_collector_if.sv - serial input and parallel output handshake bundle
interface sipo_collector_if
  import sipo_collector_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
);

  logic             serial_in;
  logic             shift_en;
  logic             frame_start;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  modport slave (
    input  serial_in,
    input  shift_en,
    input  frame_start,
    input  out_ready,
    output out_data,
    output out_valid,
    output busy,
    output overrun
  );

  modport master (
    output serial_in,
    output shift_en,
    output frame_start,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  busy,
    input  overrun
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - bit-placing shift register with saturating bit counter
module sipo_shift_reg
  import sipo_collector_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] next_word,
  output logic             complete
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0]    count;
  logic [CW-1:0]    next_count;
  logic [CW-1:0]    base_count;
  logic [WIDTH-1:0] base_word;

  // A clear in the same cycle as a shift makes the incoming bit bit 0 of a fresh frame
  always_comb begin
    base_word  = clear ? '0 : word;
    base_count = clear ? '0 : count;
    next_word  = base_word;
    next_count = base_count;
    complete   = 1'b0;
    if (shift && (base_count < FULL)) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (base_count == CW'(k)) begin
          if (MSB_FIRST) begin
            next_word[WIDTH-1-k] = bit_in;
          end else begin
            next_word[k] = bit_in;
          end
        end
      end
      next_count = base_count + 1'b1;
      complete   = (next_count == FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear || shift) begin
      word  <= next_word;
      count <= next_count;
    end
  end

endmodule

// File: rtl/sipo_collector.sv
// rtl/sipo_collector.sv - serial-to-parallel word collector with one-deep output slot
module sipo_collector
  import sipo_collector_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sipo_collector_if.slave   bus
);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             sr_clear;
  logic             sr_shift;
  logic [WIDTH-1:0] sr_word;
  logic [WIDTH-1:0] sr_next;
  logic             sr_complete;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             slot_free;
  logic             load_new;
  logic             hold_release;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (sr_clear),
    .shift     (sr_shift),
    .bit_in    (bus.serial_in),
    .word      (sr_word),
    .next_word (sr_next),
    .complete  (sr_complete)
  );

  // The shift register only moves while a frame is open; HOLD freezes the completed word
  always_comb begin
    sr_clear = 1'b0;
    sr_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          sr_clear = 1'b1;
          sr_shift = bus.shift_en;
        end
      end
      ST_COLLECT: begin
        sr_clear = bus.frame_start;
        sr_shift = bus.shift_en;
      end
      default: ;
    endcase
  end

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign load_new     = sr_complete && slot_free;
  assign hold_release = (state == ST_HOLD) && out_valid_q && bus.out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (bus.frame_start) state_nx = ST_COLLECT;
      ST_COLLECT: state_nx = ST_COLLECT;
      ST_HOLD:    if (hold_release) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (sr_complete) begin
      state_nx = slot_free ? ST_IDLE : ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_new) begin
        out_data_q <= sr_next;
      end else if (hold_release) begin
        out_data_q <= sr_word;
      end
      if (load_new || hold_release) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // Any serial activity while a word is parked has nowhere to go
      if ((state == ST_HOLD) && (bus.shift_en || bus.frame_start)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = state_busy(state);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_collector.sv
// tb/tb_sipo_collector.sv - directed and randomized bench for sipo_collector
module tb_sipo_collector;
  import sipo_collector_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_collector_if #(.WIDTH(W)) bus_m ();
  sipo_collector_if #(.WIDTH(W)) bus_l ();

  sipo_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
  sipo_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: mode 0 idle, 1 collecting, 2 word parked waiting for the slot
  int         m_mode;
  bit         m_bits[$];
  logic       m_valid;
  logic       m_overrun;
  logic [W-1:0] m_data_m, m_data_l, m_held_m, m_held_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit msb);
    int w;
    w = 0;
    for (int k = 0; k < W; k++) begin
      if (m_bits[k]) w = w + (1 << (msb ? (W - 1 - k) : k));
    end
    return w[W-1:0];
  endfunction

  task automatic model_step(input bit r, input bit fs, input bit se, input bit sin, input bit rdy);
    bit xfer;
    bit loaded;
    if (r) begin
      m_mode = 0;
      m_bits.delete();
      m_valid = 1'b0;
      m_overrun = 1'b0;
      m_data_m = '0;
      m_data_l = '0;
      return;
    end
    xfer = m_valid && rdy;
    loaded = 1'b0;
    if (m_mode == 2) begin
      if (se || fs) m_overrun = 1'b1;
      if (xfer) begin
        m_data_m = m_held_m;
        m_data_l = m_held_l;
        loaded = 1'b1;
        m_mode = 0;
      end
    end else if (m_mode == 1 || fs) begin
      if (fs) m_bits.delete();
      m_mode = 1;
      if (se) m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        if (!m_valid || rdy) begin
          m_data_m = pack(1'b1);
          m_data_l = pack(1'b0);
          loaded = 1'b1;
          m_mode = 0;
        end else begin
          m_held_m = pack(1'b1);
          m_held_l = pack(1'b0);
          m_mode = 2;
        end
        m_bits.delete();
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (xfer) m_valid = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit fs, input bit se, input bit sin, input bit rdy);
    rst = r;
    bus_m.frame_start = fs; bus_m.shift_en = se; bus_m.serial_in = sin; bus_m.out_ready = rdy;
    bus_l.frame_start = fs; bus_l.shift_en = se; bus_l.serial_in = sin; bus_l.out_ready = rdy;
    model_step(r, fs, se, sin, rdy);
    @(posedge clk);
    #1;
    check("valid_msb", bus_m.out_valid, m_valid);
    check("valid_lsb", bus_l.out_valid, m_valid);
    check("data_msb", bus_m.out_data, m_data_m);
    check("data_lsb", bus_l.out_data, m_data_l);
    check("busy_msb", bus_m.busy, m_mode != 0);
    check("busy_lsb", bus_l.busy, m_mode != 0);
    check("overrun_msb", bus_m.overrun, m_overrun);
    check("overrun_lsb", bus_l.overrun, m_overrun);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    check("reset_state", u_msb.state, ST_IDLE);
    check("reset_data", bus_m.out_data, 4'b0000);
    check("reset_valid", bus_m.out_valid, 1'b0);

    // Back-to-back 1,0,1,1 with the consumer always ready
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    check("s1_valid_early", bus_m.out_valid, 1'b0);
    cyc(0, 0, 1, 1, 1);
    check("s1_msb_word", bus_m.out_data, 4'b1011);
    check("s1_lsb_word", bus_l.out_data, 4'b1101);
    check("s1_valid", bus_m.out_valid, 1'b1);
    cyc(0, 0, 0, 0, 1);
    check("s1_valid_once", bus_m.out_valid, 1'b0);

    // 1,1,0,0 with idle gaps between bits
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    check("s3_gap_busy", bus_m.busy, 1'b1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    check("s3_word", bus_m.out_data, 4'b1100);
    cyc(0, 0, 0, 0, 1);

    // Blocked consumer: A=1010 lands, B=0110 parks in HOLD
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    check("s4_word_a", bus_m.out_data, 4'b1010);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    check("s4_hold_state", u_msb.state, ST_HOLD);
    check("s4_hold_data", bus_m.out_data, 4'b1010);
    check("s4_overrun_clear", bus_m.overrun, 1'b0);
    cyc(0, 0, 1, 1, 0);
    check("s4_overrun", bus_m.overrun, 1'b1);
    cyc(0, 0, 0, 0, 1);
    check("s4_word_b", bus_m.out_data, 4'b0110);
    check("s4_valid_b", bus_m.out_valid, 1'b1);
    check("s4_idle", u_msb.state, ST_IDLE);
    cyc(0, 0, 0, 0, 1);

    // Restart mid-frame: 1,1 discarded, then 0,0,0,1
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    check("s5_word", bus_m.out_data, 4'b0001);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-frame, then 0111
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(1, 0, 1, 0, 1);
    check("s6_rst_data", bus_m.out_data, 4'b0000);
    check("s6_rst_valid", bus_m.out_valid, 1'b0);
    check("s6_rst_busy", bus_m.busy, 1'b0);
    check("s6_rst_overrun", bus_m.overrun, 1'b0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    check("s6_word", bus_m.out_data, 4'b0111);
    check("s6_overrun", bus_m.overrun, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1,
          $urandom_range(1) == 1, $urandom_range(2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
